spi_reg_ctrl: RTL and testbench



---
 rtl/spi_reg_ctrl.sv | 159 +++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI byte-stream command decoder driving the FPGA control/status register file.
// Optional feature macro SPI_REG_AUTOINC_EN: burst accesses walk consecutive addresses.
module spi_reg_ctrl #(
    parameter logic [7:0]  FPGA_VER  = 8'hC2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic       clk_core,
    input  logic       reset_n,
    input  logic       spi_transaction_begin,
    input  logic       spi_rx_byte_available,
    input  logic [7:0] spi_rx_byte,
    output logic [7:0] spi_tx_byte,
    output logic       force_bt,
    output logic       busy,
    output logic       reg_wr_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_t;

    localparam logic [6:0] A_VER = 7'h00;
    localparam logic [6:0] A_FBT = 7'h01;
    localparam logic [6:0] A_SCR = 7'h02;
    localparam logic [6:0] A_ERR = 7'h03;
    localparam int unsigned ERR_RD_W = (ERR_CNT_W < 8) ? ERR_CNT_W : 8;

    state_t               state_q,    state_d;
    logic [1:0]           avail_sh_q, avail_sh_d;
    logic [7:0]           tx_q,       tx_d;
    logic                 force_q,    force_d;
    logic [7:0]           scratch_q,  scratch_d;
    logic [ERR_CNT_W-1:0] err_q,      err_d;
    logic [6:0]           addr_q,     addr_d;
    logic                 rw_q,       rw_d;
    logic                 wr_pulse_q, wr_pulse_d;

    logic       byte_evt;
    logic [6:0] next_addr;
    logic [7:0] err_rd;
    logic [7:0] rd_cmd;
    logic [7:0] rd_next;

    function automatic logic [7:0] reg_read(
        input logic [6:0] a,
        input logic       fbt,
        input logic [7:0] scr,
        input logic [7:0] err
    );
        case (a)
            A_VER:   reg_read = FPGA_VER;
            A_FBT:   reg_read = {7'b0, fbt};
            A_SCR:   reg_read = scr;
            A_ERR:   reg_read = err;
            default: reg_read = '0;
        endcase
    endfunction

    // Rising edge of the available level, seen one flop after it arrives.
    assign byte_evt = (avail_sh_q == 2'b01);

`ifdef SPI_REG_AUTOINC_EN
    assign next_addr = addr_q + 7'd1;
`else
    assign next_addr = addr_q;
`endif

    assign err_rd  = 8'(err_q[ERR_RD_W-1:0]);
    assign rd_cmd  = reg_read(spi_rx_byte[6:0], force_q, scratch_q, err_rd);
    assign rd_next = reg_read(next_addr, force_q, scratch_q, err_rd);

    always_comb begin
        avail_sh_d = {avail_sh_q[0], spi_rx_byte_available};
        state_d    = state_q;
        tx_d       = tx_q;
        force_d    = force_q;
        scratch_d  = scratch_q;
        err_d      = err_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wr_pulse_d = 1'b0;

        if (spi_transaction_begin) begin
            state_d = ST_CMD;
            tx_d    = '0;
        end else if (byte_evt) begin
            case (state_q)
                ST_CMD: begin
                    addr_d  = spi_rx_byte[6:0];
                    rw_d    = spi_rx_byte[7];
                    state_d = ST_DATA;
                    if (!spi_rx_byte[7]) begin
                        tx_d = rd_cmd;
                    end
                end
                ST_DATA: begin
                    if (rw_q) begin
                        case (addr_q)
                            A_FBT: begin
                                force_d    = spi_rx_byte[0];
                                wr_pulse_d = 1'b1;
                            end
                            A_SCR: begin
                                scratch_d  = spi_rx_byte;
                                wr_pulse_d = 1'b1;
                            end
                            // Any write to the error counter clears it.
                            A_ERR: begin
                                err_d      = '0;
                                wr_pulse_d = 1'b1;
                            end
                            default: begin
                                if (err_q != '1) begin
                                    err_d = err_q + ERR_CNT_W'(1);
                                end
                            end
                        endcase
                    end else begin
                        tx_d = rd_next;
                    end
                    addr_d = next_addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            avail_sh_q <= '0;
            tx_q       <= '0;
            force_q    <= 1'b0;
            scratch_q  <= '0;
            err_q      <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            avail_sh_q <= avail_sh_d;
            tx_q       <= tx_d;
            force_q    <= force_d;
            scratch_q  <= scratch_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign spi_tx_byte  = tx_q;
    assign force_bt     = force_q;
    assign busy         = (state_q != ST_IDLE);
    assign reg_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: transaction-level reference model plus directed and random traffic.
// Honours SPI_REG_AUTOINC_EN the same way as the design.
module tb_spi_reg_ctrl;

    logic       clk_core              = 1'b0;
    logic       reset_n               = 1'b0;
    logic       spi_transaction_begin = 1'b0;
    logic       spi_rx_byte_available = 1'b0;
    logic [7:0] spi_rx_byte           = 8'h00;
    logic [7:0] spi_tx_byte;
    logic       force_bt;
    logic       busy;
    logic       reg_wr_pulse;

    spi_reg_ctrl #(
        .FPGA_VER  (8'hC2),
        .ERR_CNT_W (8)
    ) dut (
        .clk_core              (clk_core),
        .reset_n               (reset_n),
        .spi_transaction_begin (spi_transaction_begin),
        .spi_rx_byte_available (spi_rx_byte_available),
        .spi_rx_byte           (spi_rx_byte),
        .spi_tx_byte           (spi_tx_byte),
        .force_bt              (force_bt),
        .busy                  (busy),
        .reg_wr_pulse          (reg_wr_pulse)
    );

    initial forever #10 clk_core = ~clk_core;

    int unsigned vec  = 0;
    int unsigned miss = 0;

    // Reference model: what the register file and TX byte must be after each clock edge.
    typedef enum {M_IDLE, M_CMD, M_DATA} mstate_t;
    typedef struct {
        int         at;
        logic [7:0] b;
    } ev_t;

    ev_t        bq[$];
    int         cyc      = 0;
    int         begin_at = -1;
    mstate_t    m_st     = M_IDLE;
    int         m_addr   = 0;
    bit         m_rw     = 0;
    logic [7:0] m_tx     = 8'h00;
    bit         m_force  = 0;
    logic [7:0] m_scr    = 8'h00;
    int         m_err    = 0;
    bit         m_pulse  = 0;

`ifdef SPI_REG_AUTOINC_EN
    localparam logic [7:0] SCR_EXP = 8'h11;
`else
    localparam logic [7:0] SCR_EXP = 8'h22;
`endif

    function automatic logic [7:0] mread(input int a);
        case (a)
            0:       return 8'hC2;
            1:       return {7'b0, m_force};
            2:       return m_scr;
            3:       return 8'(m_err);
            default: return 8'h00;
        endcase
    endfunction

    function automatic int mnext(input int a);
`ifdef SPI_REG_AUTOINC_EN
        return (a + 1) % 128;
`else
        return a;
`endif
    endfunction

    task automatic m_reset();
        m_st = M_IDLE; m_addr = 0; m_rw = 0; m_tx = 8'h00;
        m_force = 0; m_scr = 8'h00; m_err = 0; m_pulse = 0;
        bq.delete();
        begin_at = -1;
    endtask

    task automatic m_step();
        ev_t        ev;
        bit         got;
        logic [7:0] b;
        got = 0;
        b = 8'h00;
        m_pulse = 0;
        if (bq.size() > 0 && bq[0].at == cyc) begin
            ev = bq.pop_front();
            b = ev.b;
            got = 1;
        end
        if (begin_at == cyc) begin
            m_st = M_CMD;
            m_tx = 8'h00;
        end else if (got) begin
            if (m_st == M_CMD) begin
                m_addr = int'(b[6:0]);
                m_rw = b[7];
                m_st = M_DATA;
                if (!m_rw) m_tx = mread(m_addr);
            end else if (m_st == M_DATA) begin
                if (m_rw) begin
                    if (m_addr == 1) begin m_force = b[0]; m_pulse = 1; end
                    else if (m_addr == 2) begin m_scr = b; m_pulse = 1; end
                    else if (m_addr == 3) begin m_err = 0; m_pulse = 1; end
                    else if (m_err < 255) m_err = m_err + 1;
                    m_addr = mnext(m_addr);
                end else begin
                    m_addr = mnext(m_addr);
                    m_tx = mread(m_addr);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk_core or negedge reset_n);
        if (!reset_n) begin
            m_reset();
        end else begin
            cyc = cyc + 1;
            m_step();
        end
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: dut=0x%02h expected=0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        @(posedge clk_core);
        forever begin
            @(negedge clk_core);
            check8("tx_byte", spi_tx_byte, m_tx);
            check8("force_bt", {7'b0, force_bt}, {7'b0, m_force});
            check8("busy", {7'b0, busy}, {7'b0, m_st != M_IDLE});
            check8("reg_wr_pulse", {7'b0, reg_wr_pulse}, {7'b0, m_pulse});
        end
    end

    task automatic begin_txn();
        @(posedge clk_core); #1;
        spi_transaction_begin = 1'b1;
        begin_at = cyc + 1;
        @(posedge clk_core); #1;
        spi_transaction_begin = 1'b0;
    endtask

    // A byte takes effect on the second edge after its available level rises.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_core); #1;
        spi_rx_byte = b;
        spi_rx_byte_available = 1'b1;
        bq.push_back('{at: cyc + 2, b: b});
        repeat (2) @(posedge clk_core);
        #1;
        spi_rx_byte_available = 1'b0;
        spi_rx_byte = 8'($urandom);
        @(posedge clk_core);
    endtask

    task automatic collide(input logic [7:0] b);
        @(posedge clk_core); #1;
        spi_rx_byte = b;
        spi_rx_byte_available = 1'b1;
        bq.push_back('{at: cyc + 2, b: b});
        @(posedge clk_core); #1;
        spi_transaction_begin = 1'b1;
        begin_at = cyc + 1;
        @(posedge clk_core); #1;
        spi_transaction_begin = 1'b0;
        spi_rx_byte_available = 1'b0;
        @(posedge clk_core);
    endtask

    task automatic mid_reset(input logic [7:0] b);
        @(posedge clk_core); #1;
        spi_rx_byte = b;
        spi_rx_byte_available = 1'b1;
        bq.push_back('{at: cyc + 2, b: b});
        @(posedge clk_core); #3;
        reset_n = 1'b0;
        repeat (2) @(posedge clk_core);
        #1;
        spi_rx_byte_available = 1'b0;
        @(posedge clk_core); #3;
        reset_n = 1'b1;
    endtask

    task automatic read_reg(input logic [7:0] a, input string name, input logic [7:0] exp);
        begin_txn();
        send_byte({1'b0, a[6:0]});
        @(negedge clk_core);
        check8(name, spi_tx_byte, exp);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        begin_txn();
        send_byte({1'b1, a[6:0]});
        send_byte(d);
    endtask

    function automatic logic [7:0] rand_cmd();
        logic [6:0] a;
        case ($urandom_range(0, 6))
            0: a = 7'h00;
            1: a = 7'h01;
            2: a = 7'h02;
            3: a = 7'h03;
            4: a = 7'h7F;
            5: a = 7'h04;
            default: a = 7'($urandom);
        endcase
        return {1'($urandom), a};
    endfunction

    initial begin
        int unsigned r;
        int unsigned n;

        repeat (3) @(posedge clk_core);
        #3 reset_n = 1'b1;
        @(negedge clk_core);
        check8("rst_tx", spi_tx_byte, 8'h00);
        check8("rst_force", {7'b0, force_bt}, 8'h00);
        check8("rst_busy", {7'b0, busy}, 8'h00);
        check8("rst_pulse", {7'b0, reg_wr_pulse}, 8'h00);

        read_reg(8'h00, "read_ver", 8'hC2);
        check8("busy_in_txn", {7'b0, busy}, 8'h01);

        // force_bt write latency, counted from the cycle the available level rises.
        begin_txn();
        send_byte(8'h81);
        @(posedge clk_core); #1;
        spi_rx_byte = 8'h01;
        spi_rx_byte_available = 1'b1;
        bq.push_back('{at: cyc + 2, b: 8'h01});
        @(negedge clk_core);
        check8("fbt_cycle0", {7'b0, force_bt}, 8'h00);
        @(posedge clk_core); @(negedge clk_core);
        check8("fbt_cycle1", {7'b0, force_bt}, 8'h00);
        check8("pulse_cycle1", {7'b0, reg_wr_pulse}, 8'h00);
        @(posedge clk_core); @(negedge clk_core);
        check8("fbt_cycle2", {7'b0, force_bt}, 8'h01);
        check8("pulse_cycle2", {7'b0, reg_wr_pulse}, 8'h01);
        @(posedge clk_core); #1;
        spi_rx_byte_available = 1'b0;
        @(negedge clk_core);
        check8("pulse_cycle3", {7'b0, reg_wr_pulse}, 8'h00);
        @(posedge clk_core);
        read_reg(8'h01, "read_fbt", 8'h01);

        write_reg(8'h00, 8'h55);
        write_reg(8'h05, 8'hAA);
        read_reg(8'h03, "err_two", 8'h02);
        write_reg(8'h03, 8'h00);
        read_reg(8'h03, "err_clear", 8'h00);
        for (int i = 0; i < 300; i++) write_reg(8'h00, 8'($urandom));
        read_reg(8'h03, "err_sat", 8'hFF);

        begin_txn();
        send_byte(8'h82);
        send_byte(8'h11);
        send_byte(8'h22);
        read_reg(8'h02, "burst_wr_scr", SCR_EXP);
`ifdef SPI_REG_AUTOINC_EN
        read_reg(8'h03, "burst_wr_err", 8'h00);
        read_reg(8'h00, "rburst0", 8'hC2);
        send_byte(8'h00);
        @(negedge clk_core); check8("rburst1", spi_tx_byte, 8'h01);
        send_byte(8'h00);
        @(negedge clk_core); check8("rburst2", spi_tx_byte, 8'h11);
        read_reg(8'h7F, "rwrap0", 8'h00);
        send_byte(8'h00);
        @(negedge clk_core); check8("rwrap1", spi_tx_byte, 8'hC2);
`else
        read_reg(8'h03, "burst_wr_err", 8'hFF);
        read_reg(8'h00, "rburst0", 8'hC2);
        send_byte(8'h00);
        @(negedge clk_core); check8("rburst1", spi_tx_byte, 8'hC2);
`endif

        begin_txn();
        send_byte(8'h82);
        collide(8'h99);
        @(negedge clk_core);
        check8("collide_tx", spi_tx_byte, 8'h00);
        check8("collide_busy", {7'b0, busy}, 8'h01);
        send_byte(8'h02);
        @(negedge clk_core);
        check8("collide_scr", spi_tx_byte, SCR_EXP);

        begin_txn();
        send_byte(8'h81);
        mid_reset(8'h01);
        @(negedge clk_core);
        check8("mrst_force", {7'b0, force_bt}, 8'h00);
        check8("mrst_busy", {7'b0, busy}, 8'h00);
        send_byte(8'h80);
        @(negedge clk_core);
        check8("stray_busy", {7'b0, busy}, 8'h00);
        check8("stray_tx", spi_tx_byte, 8'h00);

        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 24);
            if (r == 0) begin
                begin_txn();
                send_byte(8'h81);
                mid_reset(8'($urandom));
            end else if (r == 1) begin
                send_byte(8'($urandom));
            end else begin
                begin_txn();
                send_byte(rand_cmd());
                n = $urandom_range(0, 4);
                for (int k = 0; k < int'(n); k++) begin
                    if ($urandom_range(0, 9) == 0) collide(8'($urandom));
                    else send_byte(8'($urandom));
                end
            end
        end

        repeat (3) @(posedge clk_core);
        @(negedge clk_core);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
